// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Frame-state encoding, parity-mode constants and a frame-length calculator.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Total cycles one frame occupies on the line.
  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity_en, input int stop_bits);
    return clks_per_bit * (1 + data_bits + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake, runtime config and line/status outputs of uart_tx_fifo.
// The DUT connects through slave; the word source and observers use master.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] data;
  logic                 dvalid;
  logic                 ready;
  logic                 parity_en;
  logic                 parity_odd;
  logic                 tx;
  logic                 busy;
  logic [LVL_W-1:0]     level;

  modport master (
    output data, dvalid, parity_en, parity_odd,
    input  ready, tx, busy, level
  );

  modport slave (
    input  data, dvalid, parity_en, parity_odd,
    output ready, tx, busy, level
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy count; read data is the registered head entry.
// No bypass paths: a word written this cycle is visible at the head next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame serialiser with optional parity and 1/2 stop bits.
// Frames chain back-to-back while the FIFO holds words; tx is a registered output.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input logic            clk,
  input logic            reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic [CNT_W-1:0]     clk_cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 tx_q;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_count;
  logic                 clk_last;
  logic                 stop_last;
  logic                 head_par;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fifo_push),
    .push_dat_i (bus.data),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign fifo_push  = bus.dvalid && !fifo_full;
  assign bus.ready  = !fifo_full;
  assign bus.level  = fifo_count;
  assign bus.busy   = (state_q != ST_IDLE) || (fifo_count != '0);
  assign bus.tx     = tx_q;

  assign clk_last  = (clk_cnt_q == CNT_LAST);
  assign stop_last = (bit_idx_q == STOP_LAST);
  // Parity of the head word, resolved once at pop so later config changes cannot leak in.
  assign head_par  = (^fifo_dat) ^ (bus.parity_odd == PARITY_ODD);

  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == ST_IDLE) begin
        fifo_pop = 1'b1;
      end else if ((state_q == ST_STOP) && clk_last && stop_last) begin
        fifo_pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (fifo_pop) begin
            state_q   <= ST_START;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= fifo_dat;
            par_en_q  <= bus.parity_en;
            par_bit_q <= head_par;
            tx_q      <= 1'b0;
          end
        end

        ST_START: begin
          if (clk_last) begin
            state_q   <= ST_DATA;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (clk_last) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == BIT_LAST) begin
              bit_idx_q <= '0;
              if (par_en_q) begin
                state_q <= ST_PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shreg_q   <= shreg_q >> 1;
              tx_q      <= shreg_q[1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        ST_PARITY: begin
          if (clk_last) begin
            state_q   <= ST_STOP;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          // bit_idx_q doubles as the stop-bit counter here.
          if (clk_last) begin
            clk_cnt_q <= '0;
            if (stop_last) begin
              bit_idx_q <= '0;
              if (fifo_pop) begin
                state_q   <= ST_START;
                shreg_q   <= fifo_dat;
                par_en_q  <= bus.parity_en;
                par_bit_q <= head_par;
                tx_q      <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          tx_q      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (default format, and 7 data bits / 2 stop bits)
// checked against a per-cycle line waveform built from the frame rules.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       dv;
  logic [7:0] dat;
  logic       pen;
  logic       podd;

  int checks   = 0;
  int failures = 0;

  bit exp_q[$];
  int src_q[$];
  int acc_q[$];

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus_a ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH)) bus_b ();

  assign bus_a.data       = dat;
  assign bus_a.dvalid     = dv & ~sel;
  assign bus_a.parity_en  = pen;
  assign bus_a.parity_odd = podd;
  assign bus_b.data       = dat[6:0];
  assign bus_b.dvalid     = dv & sel;
  assign bus_b.parity_en  = pen;
  assign bus_b.parity_odd = podd;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line waveform of one frame, one entry per clock cycle.
  task automatic add_frame(input int word, input int dbits, input bit pe, input bit po, input int stops);
    bit par;
    par = (($countones(word & ((1 << dbits) - 1)) % 2) == 1) ^ po;
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < dbits; i++) begin
      repeat (CPB) exp_q.push_back(((word >> i) & 1) == 1);
    end
    if (pe) repeat (CPB) exp_q.push_back(par);
    repeat (CPB * stops) exp_q.push_back(1'b1);
  endtask

  // Producer holds dvalid while src_q has words; the line must follow exp_q from edge 1.
  task automatic run(input int ncyc, input int flip_at);
    logic rdy_prev;
    logic obs_tx;
    logic obs_busy;
    bit   exp_tx;
    acc_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (src_q.size() > 0) begin
        dv  = 1'b1;
        dat = 8'(src_q[0]);
      end else begin
        dv = 1'b0;
      end
      rdy_prev = sel ? bus_b.ready : bus_a.ready;
      step();
      if (dv && rdy_prev) begin
        acc_q.push_back(c);
        void'(src_q.pop_front());
      end
      if (c == flip_at) pen = ~pen;
      obs_tx   = sel ? bus_b.tx : bus_a.tx;
      obs_busy = sel ? bus_b.busy : bus_a.busy;
      exp_tx   = (c >= 1 && (c - 1) < exp_q.size()) ? exp_q[c - 1] : 1'b1;
      chk($sformatf("tx@%0d", c), obs_tx, exp_tx);
      chk($sformatf("busy@%0d", c), obs_busy, (exp_q.size() > 0) && (c <= exp_q.size()));
    end
    dv = 1'b0;
  endtask

  // Words beyond FIFO depth wait for a pop; pops happen once per frame.
  task automatic chk_accepts(input int n, input int flen);
    chk("accept_count", acc_q.size(), n);
    for (int k = 0; k < acc_q.size() && k < n; k++) begin
      chk($sformatf("accept_edge%0d", k), acc_q[k], (k <= DEPTH) ? k : (k - DEPTH) * flen + 2);
    end
  endtask

  initial begin
    int n;
    int base;
    int flen;
    int w0;
    int w1;

    sel = 1'b0; dv = 1'b0; dat = '0; pen = 1'b0; podd = 1'b0; reset = 1'b1;
    repeat (3) step();
    chk("rst_tx_a", bus_a.tx, 1'b1);
    chk("rst_ready_a", bus_a.ready, 1'b1);
    chk("rst_busy_a", bus_a.busy, 1'b0);
    chk("rst_level_a", bus_a.level, 0);
    chk("rst_tx_b", bus_b.tx, 1'b1);
    chk("rst_busy_b", bus_b.busy, 1'b0);
    reset = 1'b0;
    step();

    // 0xAA, no parity
    exp_q.delete(); add_frame(8'hAA, 8, 1'b0, 1'b0, 1);
    src_q = '{8'hAA};
    run(35, -1);
    chk_accepts(1, frame_cycles(CPB, 8, 0, 1));

    // 0xAA with even then odd parity
    pen = 1'b1;
    podd = 1'b0;
    exp_q.delete(); add_frame(8'hAA, 8, 1'b1, 1'b0, 1);
    src_q = '{8'hAA};
    run(38, -1);
    podd = 1'b1;
    exp_q.delete(); add_frame(8'hAA, 8, 1'b1, 1'b1, 1);
    src_q = '{8'hAA};
    run(38, -1);

    // six distinct words with dvalid held high
    pen = 1'b0; podd = 1'b0;
    base = $urandom_range(0, 249);
    exp_q.delete();
    src_q.delete();
    for (int i = 0; i < 6; i++) begin
      src_q.push_back(base + i);
      add_frame(base + i, 8, 1'b0, 1'b0, 1);
    end
    run(6 * frame_cycles(CPB, 8, 0, 1) + 5, -1);
    chk_accepts(6, frame_cycles(CPB, 8, 0, 1));

    // 7 data bits, 2 stop bits
    sel = 1'b1;
    exp_q.delete(); add_frame(8'h55, 7, 1'b0, 1'b0, 2);
    src_q = '{8'h55};
    run(35, -1);
    sel = 1'b0;

    // parity enabled mid-frame: first frame keeps its mode, second picks up the new one
    pen = 1'b0;
    podd = 1'($urandom_range(0, 1));
    w0 = $urandom_range(0, 255);
    w1 = $urandom_range(0, 255);
    exp_q.delete();
    add_frame(w0, 8, 1'b0, podd, 1);
    add_frame(w1, 8, 1'b1, podd, 1);
    src_q = '{w0, w1};
    run(30 + 33 + 4, 10);
    pen = 1'b0;

    // randomized bursts with random parity config
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 7);
      pen = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      flen = frame_cycles(CPB, 8, int'(pen), 1);
      exp_q.delete();
      src_q.delete();
      for (int i = 0; i < n; i++) begin
        w0 = $urandom_range(0, 255);
        src_q.push_back(w0);
        add_frame(w0, 8, pen, podd, 1);
      end
      run(n * flen + 4, -1);
      chk_accepts(n, flen);
    end

    // reset in the middle of the data bits with two words queued
    pen = 1'b0; podd = 1'b0;
    exp_q.delete(); add_frame(8'h00, 8, 1'b0, 1'b0, 1);
    src_q = '{8'h00, 8'h3C, 8'hC3};
    run(10, -1);
    chk("pre_rst_level", bus_a.level, 2);
    reset = 1'b1;
    step();
    chk("mid_rst_tx", bus_a.tx, 1'b1);
    chk("mid_rst_level", bus_a.level, 0);
    chk("mid_rst_ready", bus_a.ready, 1'b1);
    chk("mid_rst_busy", bus_a.busy, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      chk($sformatf("post_rst_tx@%0d", c), bus_a.tx, 1'b1);
      chk($sformatf("post_rst_busy@%0d", c), bus_a.busy, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
